cube_root_seq: RTL and testbench

Sequential, parametrised integer cube-root unit. It extracts one root bit per iteration using the binomial step factor 3y²+3y+1, evaluated as a registered pipeline stage. It generalises the team's combinational step-factor block into a complete start/done engine with selectable input width and an optional signed mode. It sits behind the datapath register file and returns the root and remainder such that x = root³ + rem.

---
 rtl/cube_root_seq_if.sv | 16 +
 rtl/cube_root_seq.sv | 144 ++++++++++++++
 tb/tb_cube_root_seq.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cube_root_seq_if.sv
// Request/result bundle for the sequential cube-root engine: start/x in, busy/done/root/rem out.
interface cube_root_seq_if #(
    parameter int IN_W = 33
) ();
    localparam int ROOT_W = IN_W / 3;

    logic                  start;
    logic [IN_W-1:0]       x;
    logic                  busy;
    logic                  done;
    logic [ROOT_W:0]       root;
    logic [2*ROOT_W+2:0]   rem;

    modport master (output start, output x, input busy, input done, input root, input rem);
    modport slave  (input start, input x, output busy, output done, output root, output rem);
endinterface

// File: rtl/cube_root_seq.sv
// Integer cube root, one root bit per FACT/STEP pair: done pulses 2*ROOT_W+1 cycles after start.
// No backpressure: start is only sampled in IDLE and ignored (never queued) while busy or in DONE.
module cube_root_seq #(
    parameter int IN_W        = 33,
    parameter int SIGNED_MODE = 0
) (
    input  logic           clk,
    input  logic           rst,
    cube_root_seq_if.slave io
);
    localparam int ROOT_W = IN_W / 3;
    localparam int B_W    = 2 * ROOT_W + 2;
    localparam int RS_W   = 2 * ROOT_W + 5;
    localparam int REM_W  = 2 * ROOT_W + 3;
    localparam int CNT_W  = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FACT = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   mag_q, mag_d;
    logic              neg_q, neg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ROOT_W-1:0] y_q, y_d;
    logic [ROOT_W-1:0] ys_q, ys_d;
    logic [RS_W-1:0]   r_q, r_d;
    logic [RS_W-1:0]   rs_q, rs_d;
    logic [B_W-1:0]    b_q, b_d;
    logic [ROOT_W:0]   root_q, root_d;
    logic [REM_W-1:0]  rem_q, rem_d;

    logic              neg_in;
    logic [2:0]        chunk;
    logic [B_W-1:0]    ys_w;
    logic [RS_W-1:0]   r_step;
    logic [ROOT_W-1:0] y_step;
    logic [ROOT_W:0]   root_mag;
    logic [REM_W-1:0]  rem_mag;

    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        ys_d     = ys_q;
        r_d      = r_q;
        rs_d     = rs_q;
        b_d      = b_q;
        root_d   = root_q;
        rem_d    = rem_q;
        neg_in   = (SIGNED_MODE != 0) && io.x[IN_W-1];
        chunk    = 3'(mag_q >> (3 * cnt_q));
        ys_w     = '0;
        r_step   = rs_q;
        y_step   = ys_q;
        root_mag = '0;
        rem_mag  = '0;

        case (state_q)
            IDLE: begin
                if (io.start) begin
                    // -2^(IN_W-1) negates to itself, which is the correct unsigned magnitude
                    mag_d   = neg_in ? -io.x : io.x;
                    neg_d   = neg_in;
                    y_d     = '0;
                    r_d     = '0;
                    cnt_d   = CNT_W'(ROOT_W - 1);
                    state_d = FACT;
                end
            end
            FACT: begin
                rs_d    = RS_W'({r_q, chunk});
                ys_d    = y_q << 1;
                ys_w    = B_W'(ys_d);
                b_d     = ys_w * ys_w * B_W'(3) + ys_w * B_W'(3) + B_W'(1);
                state_d = STEP;
            end
            STEP: begin
                if (rs_q >= RS_W'(b_q)) begin
                    r_step = rs_q - RS_W'(b_q);
                    y_step = ys_q + ROOT_W'(1);
                end
                r_d = r_step;
                y_d = y_step;
                if (cnt_q == '0) begin
                    // Results are published on entry to DONE and held until the next one
                    root_mag = {1'b0, y_step};
                    rem_mag  = REM_W'(r_step);
                    root_d   = neg_q ? -root_mag : root_mag;
                    rem_d    = neg_q ? -rem_mag : rem_mag;
                    state_d  = DONE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = FACT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            y_q     <= '0;
            ys_q    <= '0;
            r_q     <= '0;
            rs_q    <= '0;
            b_q     <= '0;
            root_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            ys_q    <= ys_d;
            r_q     <= r_d;
            rs_q    <= rs_d;
            b_q     <= b_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
        end
    end

    assign io.busy = (state_q != IDLE);
    assign io.done = (state_q == DONE);
    assign io.root = root_q;
    assign io.rem  = rem_q;

endmodule

// File: tb/tb_cube_root_seq.sv
// Bench for cube_root_seq: an unsigned and a signed instance share clk/rst, checked against a cycle model.
module tb_cube_root_seq;
    localparam int IN_W  = 33;
    localparam int RW    = IN_W / 3;
    localparam int REMW  = 2 * RW + 3;
    localparam int LAT   = 2 * RW + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic              st     [2];
    logic [IN_W-1:0]   xv     [2];
    logic              busy_a [2];
    logic              done_a [2];
    logic [RW:0]       root_a [2];
    logic [REMW-1:0]   rem_a  [2];

    int vectors = 0;
    int errors  = 0;

    cube_root_seq_if #(.IN_W(IN_W)) ifu ();
    cube_root_seq_if #(.IN_W(IN_W)) ifs ();

    cube_root_seq #(.IN_W(IN_W), .SIGNED_MODE(0)) dut_u (.clk(clk), .rst(rst), .io(ifu));
    cube_root_seq #(.IN_W(IN_W), .SIGNED_MODE(1)) dut_s (.clk(clk), .rst(rst), .io(ifs));

    assign ifu.start = st[0];
    assign ifu.x     = xv[0];
    assign ifs.start = st[1];
    assign ifs.x     = xv[1];
    assign busy_a[0] = ifu.busy;
    assign done_a[0] = ifu.done;
    assign root_a[0] = ifu.root;
    assign rem_a[0]  = ifu.rem;
    assign busy_a[1] = ifs.busy;
    assign done_a[1] = ifs.done;
    assign root_a[1] = ifs.root;
    assign rem_a[1]  = ifs.rem;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plain-arithmetic reference: floor cube root of |x|, remainder, sign reapplied
    function automatic longint icbrt(input longint m);
        longint lo = 0;
        longint hi = 2049;
        longint mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid * mid <= m) lo = mid;
            else                      hi = mid;
        end
        return lo;
    endfunction

    task automatic model_eval(input int d, input logic [IN_W-1:0] xin,
                              output logic [RW:0] er, output logic [REMW-1:0] erem);
        longint xl, m, rt, rm;
        xl = (d == 1) ? longint'($signed(xin)) : longint'(xin);
        m  = (xl < 0) ? -xl : xl;
        rt = icbrt(m);
        rm = m - rt * rt * rt;
        if (xl < 0) begin
            rt = -rt;
            rm = -rm;
        end
        er   = (RW + 1)'(rt);
        erem = REMW'(rm);
    endtask

    int              left   [2] = '{0, 0};
    logic [RW:0]     e_root [2] = '{'0, '0};
    logic [REMW-1:0] e_rem  [2] = '{'0, '0};
    logic [RW:0]     p_root [2];
    logic [REMW-1:0] p_rem  [2];

    initial forever begin
        @(posedge clk or posedge rst);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                left[d]   = 0;
                e_root[d] = '0;
                e_rem[d]  = '0;
            end else if (left[d] == 0) begin
                if (st[d]) begin
                    left[d] = LAT;
                    model_eval(d, xv[d], p_root[d], p_rem[d]);
                end
            end else begin
                left[d] = left[d] - 1;
                if (left[d] == 1) begin
                    e_root[d] = p_root[d];
                    e_rem[d]  = p_rem[d];
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk((d == 0) ? "cmp_busy_u" : "cmp_busy_s", longint'(busy_a[d]), longint'(left[d] > 0));
            chk((d == 0) ? "cmp_done_u" : "cmp_done_s", longint'(done_a[d]), longint'(left[d] == 1));
            chk((d == 0) ? "cmp_root_u" : "cmp_root_s", longint'(root_a[d]), longint'(e_root[d]));
            chk((d == 0) ? "cmp_rem_u"  : "cmp_rem_s",  longint'(rem_a[d]),  longint'(e_rem[d]));
        end
    end

    task automatic wait_done(input int d, output int n, output int bc);
        n  = 1;
        bc = 0;
        while (!done_a[d] && n < 40) begin
            if (busy_a[d]) bc++;
            tick();
            n++;
        end
        if (busy_a[d]) bc++;
    endtask

    // Called in cycle k+1; ends in the IDLE cycle after DONE
    task automatic finish_op(input int d, input longint er, input longint erem, input string nm);
        int n, bc;
        logic [RW:0]     rx;
        logic [REMW-1:0] mx;
        rx = (RW + 1)'(er);
        mx = REMW'(erem);
        wait_done(d, n, bc);
        chk({nm, "_latency"}, n, LAT);
        chk({nm, "_busy_cycles"}, bc, LAT);
        chk({nm, "_root"}, longint'(root_a[d]), longint'(rx));
        chk({nm, "_rem"}, longint'(rem_a[d]), longint'(mx));
        tick();
        chk({nm, "_idle_busy"}, longint'(busy_a[d]), 0);
    endtask

    task automatic run(input int d, input longint xin, input longint er, input longint erem, input string nm);
        xv[d] = IN_W'(xin);
        st[d] = 1'b1;
        tick();
        st[d] = 1'b0;
        xv[d] = '0;
        finish_op(d, er, erem, nm);
    endtask

    task automatic stress(input int d);
        logic [IN_W-1:0] xs;
        longint xl, rl, ml, ar, am;
        int n, bc;
        for (int i = 0; i < 1000; i++) begin
            xs    = IN_W'({$urandom(), $urandom()});
            xv[d] = xs;
            st[d] = 1'b1;
            tick();
            st[d] = 1'b0;
            xv[d] = IN_W'({$urandom(), $urandom()});
            wait_done(d, n, bc);
            chk("stress_latency", n, LAT);
            xl = (d == 1) ? longint'($signed(xs)) : longint'(xs);
            rl = (d == 1) ? longint'($signed(root_a[d])) : longint'(root_a[d]);
            ml = (d == 1) ? longint'($signed(rem_a[d])) : longint'(rem_a[d]);
            ar = (rl < 0) ? -rl : rl;
            am = (ml < 0) ? -ml : ml;
            chk("stress_sum", rl * rl * rl + ml, xl);
            chk("stress_rem_bound", longint'(am <= 3 * ar * ar + 3 * ar), 1);
            chk("stress_rem_sign", longint'((xl < 0) ? (ml <= 0) : (ml >= 0)), 1);
            tick();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd, got_root, n, bc;
        st[0] = 1'b1;
        xv[0] = IN_W'(27);
        st[1] = 1'b0;
        xv[1] = '0;
        #1;
        chk("reset_busy", longint'(busy_a[0]), 0);
        chk("reset_done", longint'(done_a[0]), 0);
        chk("reset_root", longint'(root_a[0]), 0);
        chk("reset_rem",  longint'(rem_a[0]), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        st[0] = 1'b0;
        finish_op(0, 3, 0, "start_held_through_reset");

        run(0, 0, 0, 0, "u_0");
        run(0, 27, 3, 0, "u_27");
        run(0, 1000, 10, 0, "u_1000");
        run(0, 1001, 10, 1, "u_1001");
        run(0, 64'd8589934591, 2047, 12576768, "u_max");

        run(1, -30, -3, -3, "s_m30");
        run(1, -64'sd4294967296, -1625, -3951671, "s_min");
        run(1, 64, 4, 0, "s_64");

        // start while busy and in DONE is dropped; start in the following IDLE cycle is taken
        xv[0] = IN_W'(27);
        st[0] = 1'b1;
        tick();
        nd = 0;
        got_root = -1;
        for (int k = 1; k <= LAT; k++) begin
            st[0] = (k == 5) || (k == LAT);
            if (k == 5 || k == LAT) xv[0] = IN_W'(8);
            if (done_a[0]) begin
                nd++;
                got_root = int'(root_a[0]);
            end
            if (k < LAT) tick();
        end
        tick();
        chk("ignore_idle_done", longint'(done_a[0]), 0);
        tick();
        st[0] = 1'b0;
        chk("ignore_done_count", nd, 1);
        chk("ignore_root", got_root, 3);
        finish_op(0, 2, 0, "restart_8");

        // reset mid-operation discards the result and clears outputs at once
        xv[0] = IN_W'(1000);
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        rst = 1'b1;
        #1;
        chk("midrst_busy", longint'(busy_a[0]), 0);
        chk("midrst_done", longint'(done_a[0]), 0);
        chk("midrst_root", longint'(root_a[0]), 0);
        chk("midrst_rem",  longint'(rem_a[0]), 0);
        tick();
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 30; k++) begin
            if (done_a[0]) nd++;
            tick();
        end
        chk("midrst_no_done", nd, 0);

        wait_done(0, n, bc);
        chk("midrst_idle_busy", bc, 0);

        fork
            stress(0);
            stress(1);
        join

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
